// File: rtl/cpu6_csr_file.sv
// cpu6_csr_file: machine-mode CSR file with trap/mret stacking, interrupt gating and 64-bit counters
module cpu6_csr_file #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET  = 32'h0000_0100,
  parameter bit              HAS_COUNTERS = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            csr_rd_en,
  input  logic            csr_wr_en,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_idx,
  input  logic [XLEN-1:0] csr_write_dat,
  output logic [XLEN-1:0] csr_read_dat,
  output logic            csr_illegal,
  input  logic            excp_ena,
  input  logic [XLEN-1:0] excp_mepc,
  input  logic [XLEN-1:0] excp_mcause,
  input  logic            mret_ena,
  input  logic            instret_inc,
  input  logic            irq_ext,
  output logic [XLEN-1:0] csr_mtvec,
  output logic [XLEN-1:0] csr_mepc,
  output logic            irq_take
);
  localparam logic [XLEN-1:0] MASK1 = {{(XLEN-1){1'b1}}, 1'b0};
  localparam logic [XLEN-1:0] MASK2 = {{(XLEN-2){1'b1}}, 2'b0};
  logic              st_mie, st_mpie, meie;
  logic [XLEN-1:0]   mtvec, mscratch, mepc, mcause, cur, nv;
  logic [2*XLEN-1:0] mcycle, minstret;
  logic              mapped, ro_wr, wr, cyc_wr, ins_wr;
  always_comb begin
    mapped = 1'b1;
    cur    = '0;
    case (csr_idx)
      12'h300: begin
        cur[3]     = st_mie;
        cur[7]     = st_mpie;
        cur[12:11] = 2'b11;
      end
      12'h304: cur[11] = meie;
      12'h305: cur = mtvec;
      12'h340: cur = mscratch;
      12'h341: cur = mepc;
      12'h342: cur = mcause;
      12'h344: cur[11] = irq_ext;
      12'hB00: begin mapped = HAS_COUNTERS; cur = mcycle[XLEN-1:0];          end
      12'hB80: begin mapped = HAS_COUNTERS; cur = mcycle[2*XLEN-1:XLEN];     end
      12'hB02: begin mapped = HAS_COUNTERS; cur = minstret[XLEN-1:0];        end
      12'hB82: begin mapped = HAS_COUNTERS; cur = minstret[2*XLEN-1:XLEN];   end
      default: mapped = 1'b0;
    endcase
  end
  // mip is read-only: only a set/clear with a zero mask is a legal write
  assign ro_wr = csr_wr_en & (csr_idx == 12'h344) &
                 ((csr_op == 2'b01) | (csr_op[1] & |csr_write_dat));
  assign csr_illegal  = (csr_rd_en | csr_wr_en) & (~mapped | ro_wr);
  assign csr_read_dat = csr_rd_en ? cur : '0;
  assign nv = (csr_op == 2'b01) ? csr_write_dat :
              (csr_op == 2'b10) ? (cur | csr_write_dat) : (cur & ~csr_write_dat);
  assign wr     = csr_wr_en & |csr_op & ~csr_illegal & ~excp_ena & ~mret_ena;
  assign cyc_wr = wr & ((csr_idx == 12'hB00) | (csr_idx == 12'hB80));
  assign ins_wr = wr & ((csr_idx == 12'hB02) | (csr_idx == 12'hB82));
  assign csr_mtvec = mtvec;
  assign csr_mepc  = mepc;
  assign irq_take  = st_mie & meie & irq_ext;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      meie     <= 1'b0;
      mtvec    <= MTVEC_RESET & MASK2;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (HAS_COUNTERS && !cyc_wr) mcycle <= mcycle + 1'b1;
      if (HAS_COUNTERS && !ins_wr && instret_inc) minstret <= minstret + 1'b1;
      if (excp_ena) begin
        mepc    <= excp_mepc & MASK1;
        mcause  <= excp_mcause;
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else if (mret_ena) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (wr) begin
        case (csr_idx)
          12'h300: begin st_mie <= nv[3]; st_mpie <= nv[7]; end
          12'h304: meie <= nv[11];
          12'h305: mtvec <= nv & MASK2;
          12'h340: mscratch <= nv;
          12'h341: mepc <= nv & MASK1;
          12'h342: mcause <= nv;
          12'hB00: mcycle[XLEN-1:0] <= nv;
          12'hB80: mcycle[2*XLEN-1:XLEN] <= nv;
          12'hB02: minstret[XLEN-1:0] <= nv;
          12'hB82: minstret[2*XLEN-1:XLEN] <= nv;
          default: ;
        endcase
      end
    end
  end
endmodule
